// File: rtl/serial_adder_seq_if.sv
// Handshake and operand/result bundle for the bit-serial adder sequencer.
// The master issues add requests; the slave (the sequencer) returns status and result.
interface serial_adder_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, fed LSB first, one bit per clock.
// Cout is registered back as the next carry-in; S is collected into a result shift register.
module fulladd (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    serial_adder_seq_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    // Only the upper WIDTH-1 result bits are ever read back; the bit that
    // would fall off the bottom on the final shift is never observed.
    logic [WIDTH-2:0] sum_sr_reg;
    logic             carry_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_sr_next;

    fulladd u_fulladd (
        .a    (a_sr_reg[0]),
        .b    (b_sr_reg[0]),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign sum_sr_next = {fa_s, sum_sr_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            sum_sr_reg <= '0;
            carry_reg  <= 1'b0;
            count_reg  <= '0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_sr_reg  <= bus.a;
                        b_sr_reg  <= bus.b;
                        carry_reg <= bus.cin;
                        count_reg <= '0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    sum_sr_reg <= sum_sr_next[WIDTH-1:1];
                    a_sr_reg   <= a_sr_reg >> 1;
                    b_sr_reg   <= b_sr_reg >> 1;
                    carry_reg  <= fa_cout;
                    count_reg  <= count_reg + 1'b1;
                    if (count_reg == LAST) begin
                        sum_reg   <= sum_sr_next;
                        cout_reg  <= fa_cout;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Status flags decode straight from the state register, so busy/done are exclusive.
    assign bus.busy = (state_reg == SHIFT);
    assign bus.done = (state_reg == DONE);
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq (WIDTH=8): expected {cout,sum} queued at
// request time and compared when done pulses; cycle-exact busy/done/hold checks.
module tb_serial_adder_seq;
    localparam int W = 8;

    logic clk;
    logic rst;

    serial_adder_seq_if #(.WIDTH(W)) bus_if ();

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    logic [W:0] exp_q[$];
    logic [W-1:0] prev_sum;
    logic prev_cout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Result monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!rst && (bus_if.busy || bus_if.done))
            check("busy_done_excl", {31'd0, bus_if.busy & bus_if.done}, 32'd0);
        if (!rst && bus_if.done === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("sum", {24'd0, bus_if.sum}, {24'd0, e[W-1:0]});
                check("cout", {31'd0, bus_if.cout}, {31'd0, e[W]});
                $display("add result sum=0x%02h cout=%0d", bus_if.sum, bus_if.cout);
            end
        end
    end

    // One add: request at a negedge, accept on the next posedge (E0), then
    // cycle-check busy/done/held outputs through E_W+1.
    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic tc, input bit disturb);
        int dc0;
        logic [W:0] e;
        @(negedge clk);
        bus_if.a     = ta;
        bus_if.b     = tb_v;
        bus_if.cin   = tc;
        bus_if.start = 1'b1;
        e = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
        exp_q.push_back(e);
        dc0 = done_count;
        $display("add request a=0x%02h b=0x%02h cin=%0d", ta, tb_v, tc);
        @(posedge clk);
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            if (k == 0) bus_if.start = 1'b0;
            check("busy_shift", {31'd0, bus_if.busy}, 32'd1);
            check("done_shift", {31'd0, bus_if.done}, 32'd0);
            check("sum_hold", {24'd0, bus_if.sum}, {24'd0, prev_sum});
            check("cout_hold", {31'd0, bus_if.cout}, {31'd0, prev_cout});
            if (disturb && k == 3) begin
                bus_if.a     = 8'hAA;
                bus_if.b     = 8'h55;
                bus_if.cin   = 1'b1;
                bus_if.start = 1'b1;
            end
            if (disturb && k == 4) bus_if.start = 1'b0;
        end
        @(negedge clk);
        check("done_pulse", {31'd0, bus_if.done}, 32'd1);
        check("busy_at_done", {31'd0, bus_if.busy}, 32'd0);
        @(negedge clk);
        check("done_drop", {31'd0, bus_if.done}, 32'd0);
        check("busy_after", {31'd0, bus_if.busy}, 32'd0);
        check("done_once", done_count - dc0, 32'd1);
        prev_sum  = e[W-1:0];
        prev_cout = e[W];
    endtask

    initial begin
        bus_if.start = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        bus_if.cin   = 1'b0;
        prev_sum     = '0;
        prev_cout    = 1'b0;

        // Reset held with start asserted: nothing may move.
        rst = 1'b1;
        bus_if.start = 1'b1;
        bus_if.a = 8'h77;
        bus_if.b = 8'h11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
            check("rst_done", {31'd0, bus_if.done}, 32'd0);
            check("rst_sum", {24'd0, bus_if.sum}, 32'd0);
            check("rst_cout", {31'd0, bus_if.cout}, 32'd0);
        end
        bus_if.start = 1'b0;
        rst = 1'b0;

        run_add(8'h01, 8'h01, 1'b0, 1'b0);
        run_add(8'hFF, 8'h01, 1'b0, 1'b0);
        run_add(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_add(8'h12, 8'h34, 1'b0, 1'b1);

        // Abort during the 4th shift cycle.
        @(negedge clk);
        bus_if.a = 8'h33;
        bus_if.b = 8'h44;
        bus_if.cin = 1'b1;
        bus_if.start = 1'b1;
        $display("add request a=0x33 b=0x44 cin=1 (to be aborted)");
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus_if.start = 1'b0;
        end
        check("busy_pre_abort", {31'd0, bus_if.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, bus_if.busy}, 32'd0);
        check("abort_sum", {24'd0, bus_if.sum}, 32'd0);
        check("abort_cout", {31'd0, bus_if.cout}, 32'd0);
        begin
            int dc0;
            dc0 = done_count;
            for (int i = 0; i < 2; i++) @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < W + 2; i++) begin
                @(negedge clk);
                check("abort_no_done", {31'd0, bus_if.done}, 32'd0);
            end
            check("abort_done_cnt", done_count - dc0, 32'd0);
        end
        prev_sum  = '0;
        prev_cout = 1'b0;

        run_add(8'h5A, 8'h3C, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++)
            run_add(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 1'b0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
